// File: rtl/shift_reg_n.sv
// shift_reg_n: WIDTH-bit serial-in shift stage with selectable direction,
// synchronous parallel load, a storage latch driving tri-stated outputs,
// a cascade serial output and a saturating shift counter with full flag.
//
// Optional feature macro: SHIFT_REG_N_AUTO_STORE_EN
//   When defined, the edge that shifts the counter from WIDTH-1 to WIDTH
//   also captures the post-shift word into storage and clears the counter,
//   so full never asserts. When undefined, storage updates only through st.

module shift_reg_n #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       cp,
  input  logic                       mr,
  input  logic                       ds,
  input  logic                       sh_en,
  input  logic                       dir,
  input  logic                       pl,
  input  logic [WIDTH-1:0]           d,
  input  logic                       st,
  input  logic                       oen,
  output logic [WIDTH-1:0]           q,
  output logic                       qs,
  output logic [$clog2(WIDTH+1)-1:0] cnt,
  output logic                       full,
  output logic                       stp
);

  localparam int             CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] sr;         // shift stage
  logic [WIDTH-1:0] stor;       // storage latch
  logic [WIDTH-1:0] shift_nxt;  // shift stage value after this edge
  logic [WIDTH-1:0] store_val;  // value storage takes when it updates
  logic [CW-1:0]    cnt_nxt;
  logic             auto_st;
  logic             store_upd;

  // Next shift-stage value: load beats shift, shift beats hold.
  always_comb begin
    shift_nxt = sr;
    if (pl) begin
      shift_nxt = d;
    end else if (sh_en) begin
      shift_nxt = dir ? {ds, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], ds};
    end
  end

`ifdef SHIFT_REG_N_AUTO_STORE_EN
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  // The word completes on this edge only when a real shift happens (no load).
  assign auto_st = !pl && sh_en && (cnt == CNT_LAST);
`else
  assign auto_st = 1'b0;
`endif

  // A manual strobe copies the pre-edge stage; an auto store takes the
  // post-shift word and overrides a coincident manual strobe.
  assign store_upd = st | auto_st;
  assign store_val = auto_st ? shift_nxt : sr;

  // Counter: any load or storage update clears it, otherwise shifts count up
  // and saturate at WIDTH.
  always_comb begin
    cnt_nxt = cnt;
    if (pl || store_upd) begin
      cnt_nxt = '0;
    end else if (sh_en && (cnt != CNT_MAX)) begin
      cnt_nxt = cnt + CW'(1);
    end
  end

  // All registered state, cleared asynchronously by mr.
  always_ff @(posedge cp or posedge mr) begin
    if (mr) begin
      sr   <= RESET_VAL;
      stor <= RESET_VAL;
      cnt  <= '0;
      stp  <= 1'b0;
    end else begin
      sr  <= shift_nxt;
      cnt <= cnt_nxt;
      stp <= store_upd;
      if (store_upd) begin
        stor <= store_val;
      end
    end
  end

  // Outputs: q is tri-stated purely by oen, qs is the end of the chain
  // that the current direction shifts out of.
  assign q    = oen ? {WIDTH{1'bz}} : stor;
  assign qs   = dir ? sr[0] : sr[WIDTH-1];
  assign full = (cnt == CNT_MAX);

endmodule

// File: tb/tb_shift_reg_n.sv
// tb_shift_reg_n: table-driven directed bench for shift_reg_n (WIDTH=8,
// RESET_VAL=8'h5A), plus hand-written reset, counter and word sequences.

module tb_shift_reg_n;

  localparam int          W  = 8;
  localparam logic [7:0]  RV = 8'h5A;

  logic       cp = 1'b0;
  logic       mr, ds, sh_en, dir, pl, st, oen;
  logic [7:0] d;
  logic [7:0] q;
  logic       qs, full, stp;
  logic [3:0] cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic       pl;
    logic [7:0] d;
    logic       sh_en;
    logic       dir;
    logic       ds;
    logic       st;
    logic [7:0] q;
    logic       qs;
    logic [3:0] cnt;
    logic       stp;
  } vec_t;

  vec_t tbl[$];

  shift_reg_n #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .cp(cp), .mr(mr), .ds(ds), .sh_en(sh_en), .dir(dir), .pl(pl),
    .d(d), .st(st), .oen(oen), .q(q), .qs(qs), .cnt(cnt), .full(full),
    .stp(stp)
  );

  // Clock
  always #5 cp = ~cp;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic p, input logic [7:0] dd, input logic sh,
                     input logic dr, input logic s, input logic stb,
                     input logic [7:0] eq, input logic eqs,
                     input logic [3:0] ecnt, input logic estp);
    vec_t v;
    v.pl = p; v.d = dd; v.sh_en = sh; v.dir = dr; v.ds = s; v.st = stb;
    v.q = eq; v.qs = eqs; v.cnt = ecnt; v.stp = estp;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic p, input logic [7:0] dd, input logic sh,
                       input logic dr, input logic s, input logic stb);
    pl = p; d = dd; sh_en = sh; dir = dr; ds = s; st = stb;
  endtask

  // One clock edge, then settle away from the edge before sampling.
  task automatic step();
    @(posedge cp);
    #1;
  endtask

  initial begin
    logic [7:0] zz;
    logic [7:0] pat;
    int         ecnt;
    zz  = 'z;
    pat = 8'hA5;

    // ---- reset and tri-state ----
    mr = 1'b1; oen = 1'b1;
    drive(0, 8'h00, 0, 0, 0, 0);
    #2;
    chk("reset_q_z", q, zz);
    oen = 1'b0;
    #1;
    chk("reset_q", q, RV);
    chk("reset_cnt", cnt, 4'd0);
    chk("reset_stp", stp, 1'b0);
    chk("reset_full", full, 1'b0);
    drive(0, 8'h00, 1, 0, 1, 1);
    step();
    chk("reset_hold_cnt", cnt, 4'd0);
    chk("reset_hold_q", q, RV);
    drive(0, 8'h00, 0, 0, 0, 0);
    mr = 1'b0;
    step();

    // ---- table ----
    add(1, 8'h00, 0, 0, 0, 0, 8'h5A, 0, 0, 0);
    add(0, 8'h00, 1, 0, 1, 0, 8'h5A, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 0, 8'h5A, 0, 2, 0);
    add(0, 8'h00, 1, 0, 0, 0, 8'h5A, 0, 3, 0);
    add(0, 8'h00, 1, 0, 0, 0, 8'h5A, 0, 4, 0);
    add(0, 8'h00, 1, 0, 0, 0, 8'h5A, 0, 5, 0);
    add(0, 8'h00, 1, 0, 0, 0, 8'h5A, 0, 6, 0);
    add(0, 8'h00, 0, 0, 0, 1, 8'h20, 0, 0, 1);
    add(0, 8'h00, 0, 0, 0, 0, 8'h20, 0, 0, 0);
    add(1, 8'h81, 0, 1, 0, 0, 8'h20, 1, 0, 0);
    add(0, 8'h00, 1, 1, 0, 0, 8'h20, 0, 1, 0);
    add(0, 8'h00, 0, 1, 0, 1, 8'h40, 0, 0, 1);
    add(0, 8'h00, 1, 1, 0, 1, 8'h40, 0, 0, 1);
    add(0, 8'h00, 0, 1, 0, 1, 8'h20, 0, 0, 1);
    add(0, 8'h00, 0, 1, 0, 0, 8'h20, 0, 0, 0);
    add(1, 8'h3C, 1, 0, 1, 0, 8'h20, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1, 8'h3C, 0, 0, 1);
    add(0, 8'h00, 1, 1, 1, 0, 8'h3C, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 0, 8'h3C, 0, 2, 0);
    add(0, 8'h00, 1, 1, 1, 0, 8'h3C, 0, 3, 0);
    add(1, 8'h00, 0, 0, 0, 1, 8'h9E, 0, 0, 1);
    add(1, 8'h80, 0, 0, 0, 0, 8'h9E, 1, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].pl, tbl[i].d, tbl[i].sh_en, tbl[i].dir, tbl[i].ds,
            tbl[i].st);
      step();
      chk($sformatf("vec%0d_q", i), q, tbl[i].q);
      chk($sformatf("vec%0d_qs", i), qs, tbl[i].qs);
      chk($sformatf("vec%0d_cnt", i), cnt, tbl[i].cnt);
      chk($sformatf("vec%0d_full", i), full, tbl[i].cnt == 4'd8);
      chk($sformatf("vec%0d_stp", i), stp, tbl[i].stp);
    end

    // ---- reset mid-operation and asynchronous oen ----
    drive(0, 8'h00, 1, 0, 1, 0);
    repeat (3) step();
    chk("mid_cnt", cnt, 4'd3);
    mr = 1'b1;
    #1;
    chk("mid_rst_cnt", cnt, 4'd0);
    chk("mid_rst_q", q, RV);
    chk("mid_rst_qs", qs, 1'b0);
    step();
    chk("mid_rst_hold_cnt", cnt, 4'd0);
    mr = 1'b0;
    drive(0, 8'h00, 0, 0, 0, 0);
    oen = 1'b1;
    #1;
    chk("oen_async_z", q, zz);
    oen = 1'b0;
    #1;
    chk("oen_async_drive", q, RV);

    // ---- counter saturation / auto store ----
    drive(1, 8'h00, 0, 0, 0, 0);
    step();
    chk("cnt_load", cnt, 4'd0);
    drive(0, 8'h00, 1, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step();
`ifdef SHIFT_REG_N_AUTO_STORE_EN
      ecnt = (i < 8) ? i : i - 8;
`else
      ecnt = (i < 8) ? i : 8;
`endif
      chk($sformatf("cnt_shift%0d", i), cnt, ecnt);
      chk($sformatf("full_shift%0d", i), full, ecnt == 8);
    end
    drive(1, 8'h00, 0, 0, 0, 0);
    step();
    chk("cnt_after_pl", cnt, 4'd0);
    chk("full_after_pl", full, 1'b0);

    // ---- shift in 8'hA5 MSB first without a strobe ----
    for (int i = 7; i >= 0; i--) begin
      drive(0, 8'h00, 1, 0, pat[i], 0);
      step();
    end
`ifdef SHIFT_REG_N_AUTO_STORE_EN
    chk("word_q", q, 8'hA5);
    chk("word_cnt", cnt, 4'd0);
    chk("word_full", full, 1'b0);
    chk("word_stp", stp, 1'b1);
`else
    chk("word_q", q, RV);
    chk("word_cnt", cnt, 4'd8);
    chk("word_full", full, 1'b1);
    chk("word_stp", stp, 1'b0);
`endif
    drive(0, 8'h00, 0, 0, 0, 0);
    step();
    chk("word_stp_drop", stp, 1'b0);
    chk("word_qs", qs, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/shift_reg_n.md
Name: shift_reg_n

Overview:
- Parametrised successor to the 8-bit SIPO/storage-latch shift register model.
- Single-clock, WIDTH-bit shift stage with:
  - selectable shift direction;
  - synchronous parallel load;
  - separate storage latch driving tri-stated outputs;
  - cascade serial output;
  - shift counter with full flag.
- Used by emulator front-panel and I/O paths where chained 8-bit parts are replaced by one wide register.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VAL, 0, value loaded into both shift stage and storage latch on reset; WIDTH bits.

Ports:
- cp  in  1  clock; all state updates on rising edge.
- mr  in  1  master reset, asynchronous, active-high.
- ds  in  1  serial data in.
- sh_en  in  1  shift enable.
- dir  in  1  direction select:
  - 0: ds enters bit 0, shift toward MSB.
  - 1: ds enters bit WIDTH-1, shift toward LSB.
- pl  in  1  synchronous parallel load of shift stage from d.
- d  in  WIDTH  parallel load data.
- st  in  1  storage strobe; copies shift stage to storage latch.
- oen  in  1  output enable, active-low.
- q  out  WIDTH  storage latch value when oen=0; all Z when oen=1.
- qs  out  1  cascade out, never tri-stated:
  - dir=0: shift stage bit WIDTH-1.
  - dir=1: shift stage bit 0.
- cnt  out  $clog2(WIDTH+1)  shifts since last store or load; saturating.
- full  out  1  high when cnt==WIDTH.
- stp  out  1  one-cycle pulse, registered: storage latch was updated on the previous edge.

Behaviour:
- Reset:
  - mr=1 immediately sets shift stage=RESET_VAL, storage=RESET_VAL, cnt=0, stp=0.
  - State is held while mr=1; cp edges are ignored.
  - Release takes effect at the first cp edge with mr=0.
- Reset mid-operation: a partially shifted word is discarded and cnt returns to 0.
- q is combinational from storage and oen only; q goes Z or driven without a clock edge, including during reset.
- Shift stage, priority per edge:
  - pl=1: load d; sh_en ignored.
  - else sh_en=1: shift one position per dir.
  - else hold.
- dir may change between any two edges; each shift uses dir as sampled at that edge.
- qs follows the shift stage and dir combinationally.
- Storage:
  - st=1 at an edge captures the shift stage value present before that edge.
  - A simultaneous shift or load lands in the shift stage only, so storage lags by one shift. This matches tied-clock cascades.
- cnt rules, in priority order:
  1. pl=1 or a storage update: cnt=0.
  2. else sh_en=1 and cnt<WIDTH: cnt+1.
  3. at WIDTH, cnt saturates and full stays high.
- Simultaneous st and sh_en: cnt=0 after the edge. That shift is not counted.
- stp: set for exactly one cycle after any edge that updates storage; back-to-back stores give a continuous high.
- Latency:
  - Serial bit to q: shift edge plus store edge, so at least 2 edges.
  - d to q: pl edge plus st edge.

Optional Feature:
- Macro: SHIFT_REG_N_AUTO_STORE_EN.
- Defined:
  - When a shift edge takes cnt from WIDTH-1 to WIDTH, storage captures the post-shift value on that same edge.
  - cnt then clears to 0, full never asserts, and stp pulses next cycle.
  - A manual st on the same edge is redundant; storage still gets the post-shift value.
  - pl on that edge suppresses the auto store, because no shift occurs.
- Undefined:
  - No auto store; cnt saturates at WIDTH and full asserts.
  - Storage updates only via st.

Test Plan:
- Reset/tri-state: oen=1, mr=1 → q=Z; set oen=0 → q=RESET_VAL; pulse mr during shifting → cnt=0, q=RESET_VAL.
- WIDTH=16, dir=0: ds=1 for 1 shift, ds=0 for 5 shifts, then st → q=16'h0020, cnt=0, stp high exactly 1 cycle. Check q unchanged before st.
- dir=1, WIDTH=8: pl d=8'h81, shift 1 with ds=0 → qs=0 (bit0=0); st → q=8'h40. Then st with simultaneous shift → q=8'h40 kept from pre-edge value 8'h40, shift stage=8'h20.
- Counter, macro undefined, WIDTH=8: 10 shifts → cnt=8, full=1; pl → cnt=0, full=0.
- Macro defined, WIDTH=8, dir=0: shift in 8'hA5 MSB-first with no st → q=8'hA5 on the 8th edge, stp pulse next cycle, cnt=0, full never 1.
- Priority: pl=1, sh_en=1, d=8'h3C → shift stage=8'h3C, cnt=0; verify qs=0 (bit7 of 8'h3C).
